// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Purpose:
//   Serial sequence detector with a runtime-programmable pattern and length.
//   Matches may be overlapping or non-overlapping. A saturating match counter
//   keeps a running total of matches.
//
// Parameters:
//   PAT_W  maximum pattern length in bits (>= 2)
//   CNT_W  match counter width
//   LEN_W  width of pat_len, derived from PAT_W
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cfg_load   latch pattern / pat_len / overlap this cycle
//   pattern    pattern bits; bit [pat_len-1] is received first, bit [0] last
//   pat_len    active pattern length, legal range 1..PAT_W
//   overlap    1 = overlapping matches allowed, 0 = non-overlapping
//   en         inp is valid this cycle
//   inp        serial data bit
//   clr_cnt    synchronous clear of match_cnt / cnt_sat
//   outp       one-cycle match pulse, registered
//   match_cnt  saturating number of matches
//   cnt_sat    match_cnt is all-ones
//   cfg_valid  a legal configuration is loaded and detection is running
//   cfg_err    the most recent cfg_load carried an illegal pat_len
// ---------------------------------------------------------------------------
module seq_detect_param #(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             en,
  input  logic             inp,
  input  logic             clr_cnt,
  output logic             outp,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             cfg_valid,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  typedef enum logic {
    IDLE,
    DETECT
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               outp_q, outp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [PAT_W-1:0]   hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [PAT_W-1:0]   len_mask;
  logic               cfg_legal;
  logic               hit;

  // State register; reset wipes history and configuration so that nothing
  // received before reset can ever contribute to a match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      outp_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      outp_q  <= outp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Match evaluation looks at the history as it will be after accepting inp.
  // The fill count guards against matching on stale or cleared history bits;
  // only the low len_q bits of history and pattern take part in the compare.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], inp};
    fill_inc   = (fill_q == PAT_W_L) ? fill_q : fill_q + 1'b1;
    len_mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    hit       = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);
    cfg_legal = (pat_len != '0) && (pat_len <= PAT_W_L);
  end

  // Next-state logic. A configuration load takes priority over a data bit in
  // the same cycle (the bit is dropped). An illegal load drops to IDLE but
  // keeps the previous configuration registers. The counter clear is applied
  // last so it overrides a simultaneous increment while outp still pulses.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    outp_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (cfg_load) begin
      if (cfg_legal) begin
        pat_d   = pattern;
        len_d   = pat_len;
        ovl_d   = overlap;
        hist_d  = '0;
        fill_d  = '0;
        err_d   = 1'b0;
        state_d = DETECT;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end else if (en && (state_q == DETECT)) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (hit) begin
        outp_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end
  end

  assign outp      = outp_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;
  assign cfg_valid = (state_q == DETECT);
  assign cfg_err   = err_q;

endmodule
